// File: rtl/riscv_uart_loader_pkg.sv
// Shared types and constants for the UART program loader.
//   loader_state_e : framing FSM states (StCsum exists only with UPG_CHECKSUM_EN)
//   rx_state_e     : UART byte receiver states
//   UartFrameBits  : bits per 8N1 frame (start + 8 data + stop)
//   UpgAdrWidth    : width of the programming-port word address
// Optional feature macro: UPG_CHECKSUM_EN
package riscv_uart_loader_pkg;

  localparam int unsigned UartFrameBits = 10;
  localparam int unsigned UpgAdrWidth   = 14;

`ifdef UPG_CHECKSUM_EN
  typedef enum logic [2:0] {
    StLen0,
    StLen1,
    StData,
    StCsum,
    StDone
  } loader_state_e;
`else
  typedef enum logic [2:0] {
    StLen0,
    StLen1,
    StData,
    StDone
  } loader_state_e;
`endif

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop,
    RxWaitHigh
  } rx_state_e;

endpackage

// File: rtl/riscv_uart_loader_uart_rx_byte.sv
// 8N1 UART byte receiver.
//   clk, rst    : clock, asynchronous active-high reset
//   rx          : serial input, idle high, LSB first
//   byte_o      : last received byte (held)
//   byte_vld_o  : one-cycle pulse when byte_o carries a new byte
//   frame_err_o : one-cycle pulse when a stop bit is sampled low
module uart_rx_byte
  import riscv_uart_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_o,
  output logic       byte_vld_o,
  output logic       frame_err_o
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);

  logic            meta_q, sync_q, prev_q;
  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      byte_q, byte_d;
  logic            vld_q, vld_d;
  logic            ferr_q, ferr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    vld_d   = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RxIdle: begin
        cnt_d = '0;
        if (prev_q && !sync_q) state_d = RxStart;
      end
      RxStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d = '0;
          bit_d = '0;
          // Start bit gone high again by its midpoint: treat as a glitch.
          state_d = sync_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (cnt_q == CntFull) begin
          cnt_d   = '0;
          shift_d = {sync_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RxStop;
        end
      end
      RxStop: begin
        if (cnt_q == CntFull) begin
          if (sync_q) begin
            byte_d  = shift_q;
            vld_d   = 1'b1;
            state_d = RxIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = RxWaitHigh;
          end
        end
      end
      RxWaitHigh: begin
        cnt_d = '0;
        if (sync_q) state_d = RxIdle;
      end
      default: state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RxIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      meta_q  <= rx;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      vld_q   <= vld_d;
      ferr_q  <= ferr_d;
    end
  end

  assign byte_o      = byte_q;
  assign byte_vld_o  = vld_q;
  assign frame_err_o = ferr_q;

endmodule

// File: rtl/riscv_uart_loader.sv
// UART program loader: receives LEN (16-bit, little-endian) followed by LEN little-endian
// 32-bit words and writes them to sequential word addresses on the upg_* port.
//   clk, rst   : clock, asynchronous active-high reset
//   rx         : UART serial input (8N1)
//   upg_rst_o  : high until the first length byte arrives
//   upg_wen_o  : one-cycle write strobe
//   upg_adr_o  : word address of the strobe (held between strobes)
//   upg_dat_o  : write data of the strobe (held between strobes)
//   upg_done_o : load complete, sticky until rst
//   err_o      : sticky framing / length / checksum error
// Optional feature macro: UPG_CHECKSUM_EN (trailing XOR checksum byte).
module riscv_uart_loader
  import riscv_uart_loader_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned BAUD      = 115_200,
  parameter int unsigned MAX_WORDS = 16384
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx,
  output logic                   upg_rst_o,
  output logic                   upg_wen_o,
  output logic [UpgAdrWidth-1:0] upg_adr_o,
  output logic [31:0]            upg_dat_o,
  output logic                   upg_done_o,
  output logic                   err_o
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;

`ifdef UPG_CHECKSUM_EN
  localparam loader_state_e StAfterData = StCsum;
`else
  localparam loader_state_e StAfterData = StDone;
`endif

  logic [7:0] rx_byte;
  logic       rx_vld;
  logic       rx_ferr;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .byte_o     (rx_byte),
    .byte_vld_o (rx_vld),
    .frame_err_o(rx_ferr)
  );

  loader_state_e          state_q, state_d;
  logic [15:0]            len_q, len_d;
  logic [1:0]             lane_q, lane_d;
  logic [31:0]            word_q, word_d;
  logic [UpgAdrWidth-1:0] widx_q, widx_d;
  logic [15:0]            wcnt_q, wcnt_d;
  logic                   wen_q, wen_d;
  logic [UpgAdrWidth-1:0] adr_q, adr_d;
  logic [31:0]            dat_q, dat_d;
  logic                   err_q, err_d;
`ifdef UPG_CHECKSUM_EN
  logic [7:0]             csum_q, csum_d;
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    lane_d  = lane_q;
    word_d  = word_q;
    widx_d  = widx_q;
    wcnt_d  = wcnt_q;
    wen_d   = 1'b0;
    adr_d   = adr_q;
    dat_d   = dat_q;
    err_d   = err_q;
`ifdef UPG_CHECKSUM_EN
    csum_d  = csum_q;
    if (rx_vld && (state_q inside {StLen0, StLen1, StData})) csum_d = csum_q ^ rx_byte;
`endif
    if (rx_ferr && state_q != StDone) err_d = 1'b1;

    case (state_q)
      StLen0: begin
        if (rx_vld) begin
          len_d[7:0] = rx_byte;
          state_d    = StLen1;
        end
      end
      StLen1: begin
        if (rx_vld) begin
          len_d[15:8] = rx_byte;
          if ({rx_byte, len_q[7:0]} == 16'd0) begin
            state_d = StAfterData;
          end else if (32'({rx_byte, len_q[7:0]}) > MAX_WORDS) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (rx_vld) begin
          word_d[{lane_q, 3'b000} +: 8] = rx_byte;
          lane_d = lane_q + 1'b1;
          if (lane_q == 2'd3) begin
            wen_d = 1'b1;
            dat_d = {rx_byte, word_q[23:0]};
            adr_d = widx_q;
          end
        end
        // Bookkeeping happens in the strobe cycle so done follows the last strobe by one cycle.
        if (wen_q) begin
          widx_d = widx_q + 1'b1;
          wcnt_d = wcnt_q + 16'd1;
          if (wcnt_q + 16'd1 == len_q) state_d = StAfterData;
        end
      end
`ifdef UPG_CHECKSUM_EN
      StCsum: begin
        if (rx_vld) begin
          if (rx_byte != csum_q) err_d = 1'b1;
          state_d = StDone;
        end
      end
`endif
      StDone: ;
      default: state_d = StLen0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StLen0;
      len_q   <= '0;
      lane_q  <= '0;
      word_q  <= '0;
      widx_q  <= '0;
      wcnt_q  <= '0;
      wen_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      err_q   <= 1'b0;
`ifdef UPG_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      widx_q  <= widx_d;
      wcnt_q  <= wcnt_d;
      wen_q   <= wen_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      err_q   <= err_d;
`ifdef UPG_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign upg_rst_o  = (state_q == StLen0);
  assign upg_wen_o  = wen_q;
  assign upg_adr_o  = adr_q;
  assign upg_dat_o  = dat_q;
  assign upg_done_o = (state_q == StDone);
  assign err_o      = err_q;

endmodule
